// File: rtl/bdd_pkg.sv
// bdd_pkg: shared definitions for the BDD classification walker.
//   - RAM1 word layout {w0, w1, w2, thr} and RAM2 word layout {leaf_t, next_t, leaf_f, next_f}
//   - attribute vector layout {a0, a1, a2}
//   - walker FSM state encoding
//   - weighted_sum helper: w0*a0 + w1*a1 + w2*a2 on unsigned 8-bit operands
package bdd_pkg;

  localparam int unsigned RAM1_DATA_WIDTH = 34;
  localparam int unsigned RAM2_DATA_WIDTH = 18;
  localparam int unsigned ADDR_WIDTH      = 8;
  localparam int unsigned ATTR_WIDTH      = 24;
  localparam int unsigned WEIGHT_WIDTH    = 8;
  localparam int unsigned THR_WIDTH       = 10;
  localparam int unsigned SUM_WIDTH       = 18;
  localparam int unsigned CLASS_WIDTH     = 8;
  localparam int unsigned DEPTH_WIDTH     = 8;
  localparam int unsigned STAT_WALKS_WIDTH = 16;

  // RAM1 field offsets
  localparam int unsigned W0_LSB  = 26;
  localparam int unsigned W1_LSB  = 18;
  localparam int unsigned W2_LSB  = 10;
  localparam int unsigned THR_LSB = 0;

  // RAM2 field offsets
  localparam int unsigned LEAF_T_BIT = 17;
  localparam int unsigned NEXT_T_LSB = 9;
  localparam int unsigned LEAF_F_BIT = 8;
  localparam int unsigned NEXT_F_LSB = 0;

  // Attribute slice offsets
  localparam int unsigned A0_LSB = 16;
  localparam int unsigned A1_LSB = 8;
  localparam int unsigned A2_LSB = 0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StEval  = 2'd2,
    StDone  = 2'd3
  } walk_state_e;

  // Three 8x8 products summed in 18 bits; 3*255*255 fits without overflow.
  function automatic logic [SUM_WIDTH-1:0] weighted_sum(
    input logic [RAM1_DATA_WIDTH-1:0] word,
    input logic [ATTR_WIDTH-1:0]      attr
  );
    logic [SUM_WIDTH-1:0] p0, p1, p2;
    p0 = SUM_WIDTH'(word[W0_LSB +: WEIGHT_WIDTH]) * SUM_WIDTH'(attr[A0_LSB +: WEIGHT_WIDTH]);
    p1 = SUM_WIDTH'(word[W1_LSB +: WEIGHT_WIDTH]) * SUM_WIDTH'(attr[A1_LSB +: WEIGHT_WIDTH]);
    p2 = SUM_WIDTH'(word[W2_LSB +: WEIGHT_WIDTH]) * SUM_WIDTH'(attr[A2_LSB +: WEIGHT_WIDTH]);
    return p0 + p1 + p2;
  endfunction

endpackage

// File: rtl/bdd_walk_ctrl_if.sv
// bdd_walk_ctrl_if: host-facing bundle of the BDD walker.
//   request  : req_valid/req_ready/req_attr
//   response : resp_valid/resp_ready/resp_class/resp_err
//   loading  : host_we/host_sel/host_addr/host_wdata/host_ready
// Modports: slave = walker side, master = host side.
interface bdd_walk_ctrl_if;
  import bdd_pkg::*;

  logic                       req_valid;
  logic                       req_ready;
  logic [ATTR_WIDTH-1:0]      req_attr;

  logic                       resp_valid;
  logic                       resp_ready;
  logic [CLASS_WIDTH-1:0]     resp_class;
  logic                       resp_err;

  logic                       host_we;
  logic                       host_sel;
  logic [ADDR_WIDTH-1:0]      host_addr;
  logic [RAM1_DATA_WIDTH-1:0] host_wdata;
  logic                       host_ready;

  modport slave (
    input  req_valid, req_attr, resp_ready, host_we, host_sel, host_addr, host_wdata,
    output req_ready, resp_valid, resp_class, resp_err, host_ready
  );

  modport master (
    output req_valid, req_attr, resp_ready, host_we, host_sel, host_addr, host_wdata,
    input  req_ready, resp_valid, resp_class, resp_err, host_ready
  );

endinterface

// File: rtl/bdd_node_eval.sv
// bdd_node_eval: combinational evaluation of one BDD node.
//   ram1_word_i : {w0, w1, w2, thr} of the current node
//   ram2_word_i : {leaf_t, next_t, leaf_f, next_f} of the current node
//   attr_i      : {a0, a1, a2} attribute vector of the walk
//   leaf_o      : selected branch terminates the walk
//   next_o      : selected branch target (node address, or class when leaf_o)
module bdd_node_eval
  import bdd_pkg::*;
(
  input  logic [RAM1_DATA_WIDTH-1:0] ram1_word_i,
  input  logic [RAM2_DATA_WIDTH-1:0] ram2_word_i,
  input  logic [ATTR_WIDTH-1:0]      attr_i,
  output logic                       leaf_o,
  output logic [ADDR_WIDTH-1:0]      next_o
);

  logic [SUM_WIDTH-1:0] sum;
  logic [SUM_WIDTH-1:0] thr_ext;
  logic                 take_t;

  always_comb begin
    sum     = weighted_sum(ram1_word_i, attr_i);
    thr_ext = SUM_WIDTH'(ram1_word_i[THR_LSB +: THR_WIDTH]);
    // Strictly greater: a sum equal to the threshold takes the false branch.
    take_t  = sum > thr_ext;
    if (take_t) begin
      leaf_o = ram2_word_i[LEAF_T_BIT];
      next_o = ram2_word_i[NEXT_T_LSB +: ADDR_WIDTH];
    end else begin
      leaf_o = ram2_word_i[LEAF_F_BIT];
      next_o = ram2_word_i[NEXT_F_LSB +: ADDR_WIDTH];
    end
  end

endmodule

// File: rtl/bdd_walk_ctrl.sv
// bdd_walk_ctrl: sequences BDD classification walks over two node RAMs and shares the RAM
// ports with host node loading.
//   clk, rst       : clock, asynchronous active-high reset
//   bus (slave)    : request / response / host load handshakes (bdd_walk_ctrl_if)
//   ram_addr       : shared address to RAM1 and RAM2
//   ram1_we/ram2_we: write enables, only ever pulsed in IDLE on a host write
//   ram_wdata      : write data (RAM2 takes [17:0])
//   ram1_rdata/ram2_rdata : synchronous read data, valid one cycle after ram_addr
// Optional feature (macro BDD_WALK_STATS_EN): adds stat_walks (completed responses, wrapping)
// and stat_last_depth (node visits of the last completed walk).
// Each node visit costs two cycles: FETCH presents the address, EVAL consumes the read data.
module bdd_walk_ctrl
  import bdd_pkg::*;
#(
  parameter int unsigned ROOT_ADDR = 0,
  parameter int unsigned MAX_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  bdd_walk_ctrl_if.slave              bus,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic                        ram1_we,
  output logic                        ram2_we,
  output logic [RAM1_DATA_WIDTH-1:0]  ram_wdata,
  input  logic [RAM1_DATA_WIDTH-1:0]  ram1_rdata,
  input  logic [RAM2_DATA_WIDTH-1:0]  ram2_rdata
`ifdef BDD_WALK_STATS_EN
  ,
  output logic [STAT_WALKS_WIDTH-1:0] stat_walks,
  output logic [DEPTH_WIDTH-1:0]      stat_last_depth
`endif
);

  walk_state_e state_q, state_d;

  logic [ATTR_WIDTH-1:0]  attr_q,  attr_d;
  logic [ADDR_WIDTH-1:0]  node_q,  node_d;
  logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
  logic [CLASS_WIDTH-1:0] class_q, class_d;
  logic                   err_q,   err_d;

  logic                   req_accept;
  logic                   resp_taken;
  logic                   eval_leaf;
  logic [ADDR_WIDTH-1:0]  eval_next;
  logic [DEPTH_WIDTH-1:0] depth_inc;
  logic                   depth_hit;

  // Host writes win over requests in IDLE.
  assign req_accept = (state_q == StIdle) && bus.req_valid && !bus.host_we;
  assign resp_taken = (state_q == StDone) && bus.resp_ready;
  assign depth_inc  = depth_q + DEPTH_WIDTH'(1);
  assign depth_hit  = depth_inc == DEPTH_WIDTH'(MAX_DEPTH);

  bdd_node_eval u_node_eval (
    .ram1_word_i (ram1_rdata),
    .ram2_word_i (ram2_rdata),
    .attr_i      (attr_q),
    .leaf_o      (eval_leaf),
    .next_o      (eval_next)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_accept) state_d = StFetch;
      StFetch: state_d = StEval;
      StEval:  state_d = (eval_leaf || depth_hit) ? StDone : StFetch;
      StDone:  if (bus.resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: handshakes and RAM port arbitration
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.host_ready = 1'b0;
    bus.resp_valid = 1'b0;
    ram_addr       = node_q;
    ram1_we        = 1'b0;
    ram2_we        = 1'b0;
    ram_wdata      = '0;
    unique case (state_q)
      StIdle: begin
        bus.host_ready = 1'b1;
        bus.req_ready  = !bus.host_we;
        if (bus.host_we) begin
          ram_addr  = bus.host_addr;
          ram1_we   = !bus.host_sel;
          ram2_we   = bus.host_sel;
          ram_wdata = bus.host_wdata;
        end
      end
      StDone:  bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.resp_class = class_q;
  assign bus.resp_err   = err_q;

  // Walk datapath next-state
  always_comb begin
    attr_d  = attr_q;
    node_d  = node_q;
    depth_d = depth_q;
    class_d = class_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_accept) begin
          attr_d  = bus.req_attr;
          node_d  = ADDR_WIDTH'(ROOT_ADDR);
          depth_d = '0;
          err_d   = 1'b0;
        end
      end
      StEval: begin
        depth_d = depth_inc;
        if (eval_leaf) begin
          class_d = CLASS_WIDTH'(eval_next);
        end else if (depth_hit) begin
          err_d   = 1'b1;
          class_d = '0;
        end else begin
          node_d  = eval_next;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      attr_q  <= '0;
      node_q  <= ADDR_WIDTH'(ROOT_ADDR);
      depth_q <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      attr_q  <= attr_d;
      node_q  <= node_d;
      depth_q <= depth_d;
      class_q <= class_d;
      err_q   <= err_d;
    end
  end

`ifdef BDD_WALK_STATS_EN
  logic [STAT_WALKS_WIDTH-1:0] stat_walks_q, stat_walks_d;
  logic [DEPTH_WIDTH-1:0]      stat_depth_q, stat_depth_d;

  // Statistics update on the response handshake; depth_q still holds N there.
  always_comb begin
    stat_walks_d = stat_walks_q;
    stat_depth_d = stat_depth_q;
    if (resp_taken) begin
      stat_walks_d = stat_walks_q + STAT_WALKS_WIDTH'(1);
      stat_depth_d = depth_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_walks_q <= '0;
      stat_depth_q <= '0;
    end else begin
      stat_walks_q <= stat_walks_d;
      stat_depth_q <= stat_depth_d;
    end
  end

  assign stat_walks      = stat_walks_q;
  assign stat_last_depth = stat_depth_q;
`else
  logic unused_resp_taken;
  assign unused_resp_taken = resp_taken;
`endif

endmodule
